if_id_buffer: RTL and testbench

- IF/ID pipeline register directly downstream of the fetch stage.
- Pairs each instruction-memory response with the PC that fetched it and presents {pc, instr, valid} to decode.
- Handles ID stalls (hazard unit) and branch flushes; a one-entry skid absorbs a response that arrives while decode is stalled.
- When the skid is occupied, fetch is told to hold its PC.

---
 rtl/if_id_buffer_pkg.sv | 18 +
 rtl/if_id_buffer.sv | 126 ++++++++++++
 tb/tb_if_id_buffer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared types for the IF/ID pipeline buffer: state encoding, entry layout and bubble encoding.
package if_id_buffer_pkg;

   localparam int          IFID_XLEN      = 32;
   localparam logic [31:0] IFID_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      EMPTY,
      FULL,
      SKID
   } ifid_state_t;

   typedef struct packed {
      logic [IFID_XLEN-1:0] pc;
      logic [IFID_XLEN-1:0] instr;
   } ifid_entry_t;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register with a one-entry skid for responses arriving under an ID stall.
// Optional performance counters are enabled with the IFID_PERF_CNT_EN macro.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int              XLEN      = IFID_XLEN,
   parameter logic [XLEN-1:0] NOP_INSTR = IFID_NOP_INSTR
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_addr_ip,
   input  logic            instr_rvalid_ip,
   input  logic [XLEN-1:0] instr_rdata_ip,
   input  logic            stall_ip,
   input  logic            flush_ip,
   output logic [XLEN-1:0] instr_op,
   output logic [XLEN-1:0] pc_op,
   output logic            valid_op,
   output logic            fetch_stall_op,
   output logic            overflow_op
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt_op,
   output logic [31:0]     bubble_cnt_op,
   output logic [31:0]     flush_cnt_op
`endif
);

   ifid_state_t state_q, state_d;
   ifid_entry_t out_q, out_d;
   ifid_entry_t skid_q, skid_d;
   ifid_entry_t resp;
   logic        overflow_q, overflow_d;

   assign resp = '{pc: pc_addr_ip, instr: instr_rdata_ip};

   always_comb begin
      state_d    = state_q;
      out_d      = out_q;
      skid_d     = skid_q;
      overflow_d = overflow_q;

      // A flush discards everything, including a same-cycle wrong-path response.
      if (flush_ip) begin
         state_d     = EMPTY;
         out_d.instr = NOP_INSTR;
      end else if (!stall_ip) begin
         if (state_q == SKID) begin
            out_d = skid_q;
            if (instr_rvalid_ip) begin
               skid_d = resp;
            end else begin
               state_d = FULL;
            end
         end else if (instr_rvalid_ip) begin
            out_d   = resp;
            state_d = FULL;
         end else begin
            out_d.instr = NOP_INSTR;
            state_d     = EMPTY;
         end
      end else if (instr_rvalid_ip) begin
         // Under stall the response fills the first free slot; with both full it is lost.
         case (state_q)
            EMPTY: begin
               out_d   = resp;
               state_d = FULL;
            end
            FULL: begin
               skid_d  = resp;
               state_d = SKID;
            end
            default: overflow_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= EMPTY;
         out_q      <= '{pc: '0, instr: NOP_INSTR};
         skid_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         overflow_q <= overflow_d;
      end
   end

   assign instr_op       = out_q.instr;
   assign pc_op          = out_q.pc;
   assign valid_op       = (state_q != EMPTY);
   assign fetch_stall_op = (state_q == SKID);
   assign overflow_op    = overflow_q;

`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d  = stall_cnt_q + {31'd0, (stall_ip && valid_op)};
      bubble_cnt_d = bubble_cnt_q + {31'd0, !valid_op};
      flush_cnt_d  = flush_cnt_q + {31'd0, flush_ip};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign stall_cnt_op  = stall_cnt_q;
   assign bubble_cnt_op = bubble_cnt_q;
   assign flush_cnt_op  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_if_id_buffer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock;
   logic        reset;
   logic [31:0] pc_addr_ip;
   logic        instr_rvalid_ip;
   logic [31:0] instr_rdata_ip;
   logic        stall_ip;
   logic        flush_ip;
   logic [31:0] instr_op;
   logic [31:0] pc_op;
   logic        valid_op;
   logic        fetch_stall_op;
   logic        overflow_op;
`ifdef IFID_PERF_CNT_EN
   logic [31:0] stall_cnt_op;
   logic [31:0] bubble_cnt_op;
   logic [31:0] flush_cnt_op;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: an in-order queue of held instructions; head is what decode sees.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      mq[$];
   logic        m_overflow;
   logic [31:0] m_stall_cnt;
   logic [31:0] m_bubble_cnt;
   logic [31:0] m_flush_cnt;

   if_id_buffer dut (
      .clock          (clock),
      .reset          (reset),
      .pc_addr_ip     (pc_addr_ip),
      .instr_rvalid_ip(instr_rvalid_ip),
      .instr_rdata_ip (instr_rdata_ip),
      .stall_ip       (stall_ip),
      .flush_ip       (flush_ip),
      .instr_op       (instr_op),
      .pc_op          (pc_op),
      .valid_op       (valid_op),
      .fetch_stall_op (fetch_stall_op),
      .overflow_op    (overflow_op)
`ifdef IFID_PERF_CNT_EN
      ,
      .stall_cnt_op   (stall_cnt_op),
      .bubble_cnt_op  (bubble_cnt_op),
      .flush_cnt_op   (flush_cnt_op)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drives one cycle of inputs, advances the model across the edge, then settles past it.
   task automatic step(input logic rst, input logic rv, input logic [31:0] pc,
                       input logic [31:0] data, input logic st, input logic fl);
      entry_t e;
      reset           = rst;
      instr_rvalid_ip = rv;
      pc_addr_ip      = pc;
      instr_rdata_ip  = data;
      stall_ip        = st;
      flush_ip        = fl;
      @(posedge clock);
      e.pc    = pc;
      e.instr = data;
      if (rst) begin
         mq.delete();
         m_overflow   = 1'b0;
         m_stall_cnt  = 32'd0;
         m_bubble_cnt = 32'd0;
         m_flush_cnt  = 32'd0;
      end else begin
         if (st && mq.size() > 0) m_stall_cnt = m_stall_cnt + 32'd1;
         if (mq.size() == 0) m_bubble_cnt = m_bubble_cnt + 32'd1;
         if (fl) m_flush_cnt = m_flush_cnt + 32'd1;
         if (fl) begin
            mq.delete();
         end else if (!st) begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (rv) mq.push_back(e);
         end else if (rv) begin
            if (mq.size() < 2) mq.push_back(e);
            else m_overflow = 1'b1;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (valid_op !== 1'b0 || instr_op !== NOP || pc_op !== 32'h0 ||
          fetch_stall_op !== 1'b0 || overflow_op !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset: valid=%0b instr=%h pc=%h fstall=%0b ovf=%0b, want 0 %h 0 0 0",
                  valid_op, instr_op, pc_op, fetch_stall_op, overflow_op, NOP);
      end
      step(1'b0, 1'b1, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
      checks++;
      if (valid_op !== 1'b1 || instr_op !== 32'h0050_0093 || pc_op !== 32'h0) begin
         errors++;
         $display("[TB] FAIL first_capture: valid=%0b instr=%h pc=%h, want 1 00500093 0",
                  valid_op, instr_op, pc_op);
      end
   endtask

   task automatic test_skid;
      step(1'b0, 1'b1, 32'h4, 32'h0010_8113, 1'b1, 1'b0);
      checks++;
      if (valid_op !== 1'b1 || instr_op !== 32'h0050_0093 || pc_op !== 32'h0 || fetch_stall_op !== 1'b1) begin
         errors++;
         $display("[TB] FAIL skid_hold: valid=%0b instr=%h pc=%h fstall=%0b, want 1 00500093 0 1",
                  valid_op, instr_op, pc_op, fetch_stall_op);
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (valid_op !== 1'b1 || instr_op !== 32'h0010_8113 || pc_op !== 32'h4 || fetch_stall_op !== 1'b0) begin
         errors++;
         $display("[TB] FAIL skid_drain: valid=%0b instr=%h pc=%h fstall=%0b, want 1 00108113 4 0",
                  valid_op, instr_op, pc_op, fetch_stall_op);
      end
   endtask

   task automatic test_overflow;
      step(1'b0, 1'b1, 32'h8, 32'h0000_0aaa, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'hc, 32'h0000_0bbb, 1'b1, 1'b0);
      checks++;
      if (overflow_op !== 1'b1 || pc_op !== 32'h4 || instr_op !== 32'h0010_8113 || fetch_stall_op !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overflow_set: ovf=%0b pc=%h instr=%h fstall=%0b, want 1 4 00108113 1",
                  overflow_op, pc_op, instr_op, fetch_stall_op);
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (overflow_op !== 1'b1 || pc_op !== 32'h8 || instr_op !== 32'h0000_0aaa) begin
         errors++;
         $display("[TB] FAIL overflow_sticky: ovf=%0b pc=%h instr=%h, want 1 8 00000aaa",
                  overflow_op, pc_op, instr_op);
      end
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (overflow_op !== 1'b0 || valid_op !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overflow_clear: ovf=%0b valid=%0b, want 0 0", overflow_op, valid_op);
      end
   endtask

   task automatic test_flush;
      step(1'b0, 1'b1, 32'h4, 32'h0000_1111, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h8, 32'h0000_2222, 1'b0, 1'b1);
      checks++;
      if (valid_op !== 1'b0 || instr_op !== NOP) begin
         errors++;
         $display("[TB] FAIL flush_kill: valid=%0b instr=%h, want 0 %h", valid_op, instr_op, NOP);
      end
      step(1'b0, 1'b1, 32'h40, 32'h0000_3333, 1'b0, 1'b0);
      checks++;
      if (valid_op !== 1'b1 || pc_op !== 32'h40 || instr_op !== 32'h0000_3333) begin
         errors++;
         $display("[TB] FAIL flush_redirect: valid=%0b pc=%h instr=%h, want 1 40 00003333",
                  valid_op, pc_op, instr_op);
      end
   endtask

   task automatic test_flush_stall;
      step(1'b0, 1'b1, 32'h44, 32'h0000_4444, 1'b1, 1'b0);
      checks++;
      if (fetch_stall_op !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_stall_setup: fstall=%0b, want 1", fetch_stall_op);
      end
      step(1'b0, 1'b1, 32'h48, 32'h0000_5555, 1'b1, 1'b1);
      checks++;
      if (valid_op !== 1'b0 || fetch_stall_op !== 1'b0 || instr_op !== NOP || overflow_op !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_stall: valid=%0b fstall=%0b instr=%h ovf=%0b, want 0 0 %h 0",
                  valid_op, fetch_stall_op, instr_op, overflow_op, NOP);
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (valid_op !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_stall_skid_gone: valid=%0b, want 0", valid_op);
      end
   endtask

   task automatic test_random;
      logic        exp_valid;
      logic [31:0] exp_instr;
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), $urandom & 32'hffff_fffc,
              $urandom, ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 6));
         exp_valid = (mq.size() > 0);
         exp_instr = exp_valid ? mq[0].instr : NOP;
         checks++;
         if (valid_op !== exp_valid || instr_op !== exp_instr ||
             (exp_valid && pc_op !== mq[0].pc)) begin
            errors++;
            $display("[TB] FAIL rand_out cyc %0d: valid=%0b instr=%h pc=%h, want %0b %h %h",
                     i, valid_op, instr_op, pc_op, exp_valid, exp_instr, exp_valid ? mq[0].pc : 32'h0);
         end
         checks++;
         if (fetch_stall_op !== (mq.size() == 2) || overflow_op !== m_overflow) begin
            errors++;
            $display("[TB] FAIL rand_flags cyc %0d: fstall=%0b ovf=%0b, want %0b %0b",
                     i, fetch_stall_op, overflow_op, (mq.size() == 2), m_overflow);
         end
`ifdef IFID_PERF_CNT_EN
         checks++;
         if (stall_cnt_op !== m_stall_cnt || bubble_cnt_op !== m_bubble_cnt || flush_cnt_op !== m_flush_cnt) begin
            errors++;
            $display("[TB] FAIL rand_perf cyc %0d: stall=%0d bubble=%0d flush=%0d, want %0d %0d %0d",
                     i, stall_cnt_op, bubble_cnt_op, flush_cnt_op, m_stall_cnt, m_bubble_cnt, m_flush_cnt);
         end
`endif
      end
   endtask

`ifdef IFID_PERF_CNT_EN
   task automatic test_perf;
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (stall_cnt_op !== 32'd0 || bubble_cnt_op !== 32'd0 || flush_cnt_op !== 32'd0) begin
         errors++;
         $display("[TB] FAIL perf_reset: %0d %0d %0d, want 0 0 0", stall_cnt_op, bubble_cnt_op, flush_cnt_op);
      end
      step(1'b0, 1'b1, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (stall_cnt_op !== 32'd3 || flush_cnt_op !== 32'd2) begin
         errors++;
         $display("[TB] FAIL perf_counts: stall=%0d flush=%0d, want 3 2", stall_cnt_op, flush_cnt_op);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_skid();
      test_overflow();
      test_flush();
      test_flush_stall();
`ifdef IFID_PERF_CNT_EN
      test_perf();
`endif
      step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
